// File: rtl/vga_axis_pkg.sv
// Shared constants for the VGA-to-AXI4-Stream frame sequencer.
package vga_axis_pkg;
  localparam int DW_DEF    = 8;
  localparam int DIM_W_DEF = 11;
  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] STREAM     = 2'd2;
  localparam logic [1:0] DROP       = 2'd3;
endpackage

// File: rtl/vga_axis_geom_cnt.sv
// Pixel/line counters against latched geometry; flags first/last beats and line length errors.
module vga_axis_geom_cnt
  import vga_axis_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch,
  input  logic             run,
  input  logic             data_en,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic             beat,
  output logic             first,
  output logic             last,
  output logic             line_err,
  output logic             lines_ok
);
  logic [DIM_W-1:0] w_lat, h_lat, x, y;
  logic de_q, long_seen, fall;

  assign fall     = de_q & ~data_en;
  assign beat     = run & data_en & (x < w_lat);
  assign first    = (x == '0) && (y == '0);
  assign last     = (x == w_lat - DIM_W'(1));
  assign lines_ok = (y == h_lat);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_lat     <= '0;
      h_lat     <= '0;
      x         <= '0;
      y         <= '0;
      de_q      <= 1'b0;
      long_seen <= 1'b0;
      line_err  <= 1'b0;
    end else begin
      de_q     <= data_en;
      line_err <= 1'b0;
      if (latch) begin
        w_lat     <= width;
        h_lat     <= height;
        x         <= '0;
        y         <= '0;
        long_seen <= 1'b0;
      end else if (run) begin
        if (fall) begin
          x         <= '0;
          y         <= y + DIM_W'(1);
          long_seen <= 1'b0;
          line_err  <= (x < w_lat);
        end else if (data_en) begin
          // x parks at w_lat on a long line so the excess beats stay suppressed
          if (x < w_lat) x <= x + DIM_W'(1);
          else if (!long_seen) begin
            long_seen <= 1'b1;
            line_err  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/vga_axis_frame_ctrl.sv
// Frame sequencer: admits whole VGA frames onto AXI4-Stream, drops on sink overflow, counts outcomes.
module vga_axis_frame_ctrl
  import vga_axis_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DIM_W = DIM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic             v_sync,
  input  logic             data_en,
  input  logic [DW-1:0]    pixel,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tvalid,
  output logic             m_tuser,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err_line,
  output logic             err_frame,
  output logic             cfg_err
);
  logic [1:0] state;
  logic vs_q, fb, ovf, restart, geo_zero, run;
  logic g_beat, g_first, g_last, g_lines_ok;

  assign fb       = vs_q & ~v_sync;
  assign ovf      = m_tvalid & ~m_tready;
  assign geo_zero = (width == '0) || (height == '0);
  assign restart  = fb & enable & (state != IDLE);
  // a beat coinciding with a frame boundary or an overflow is never emitted
  assign run      = (state == STREAM) & ~fb & ~ovf;
  assign busy     = (state == STREAM) || (state == DROP);

  vga_axis_geom_cnt #(.DIM_W(DIM_W)) u_geom (
    .clk      (clk),
    .rst      (rst),
    .latch    (restart),
    .run      (run),
    .data_en  (data_en),
    .width    (width),
    .height   (height),
    .beat     (g_beat),
    .first    (g_first),
    .last     (g_last),
    .line_err (err_line),
    .lines_ok (g_lines_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vs_q      <= 1'b1;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tuser   <= 1'b0;
      m_tlast   <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      err_frame <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      vs_q      <= v_sync;
      err_frame <= 1'b0;
      m_tvalid  <= g_beat;
      m_tdata   <= g_beat ? pixel : '0;
      m_tuser   <= g_beat & g_first;
      m_tlast   <= g_beat & g_last;

      if (state == STREAM && fb) begin
        if (ovf || !g_lines_ok) drop_cnt <= drop_cnt + CNT_W'(1);
        else frame_cnt <= frame_cnt + CNT_W'(1);
        err_frame <= ~g_lines_ok;
      end else if (state == STREAM && ovf) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end

      if (state == IDLE) begin
        if (enable) state <= WAIT_FRAME;
      end else if (fb) begin
        if (enable) begin
          cfg_err <= geo_zero;
          state   <= geo_zero ? WAIT_FRAME : STREAM;
        end else begin
          state <= IDLE;
        end
      end else if (state == WAIT_FRAME && !enable) begin
        state <= IDLE;
      end else if (state == STREAM && ovf) begin
        state <= DROP;
      end
    end
  end
endmodule
